instr_encoder_loader: RTL
=========================

# instr_encoder_loader

Sequential instruction encoder and program loader for the RISC-V single-cycle core. It accepts instruction descriptors (class, register fields, funct fields, immediate) over a valid/ready handshake and packs each one into a 32-bit RV32I word. It then writes the words to consecutive addresses of the instruction-memory write port. It is the producing end of the instruction bus, filling program memory with opcodes that the core's control decoder later consumes.

## Interface
- ADDR_WIDTH, 8, word-address width of the instruction-memory write port
- BASE_ADDR, 0, first word address written after Start_i

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- Start_i  in  1  begin a load session (honoured in IDLE/DONE only)
- Desc_Valid_i  in  1  descriptor valid
- Desc_Ready_o  out  1  descriptor accepted when Valid & Ready
- Desc_Type_i  in  3  0 R, 1 I_LOGIC, 2 I_LOAD, 3 S_STORE, 4 U_LOAD, 5 B_BRANCH, 6 JAL, 7 JALR
- Funct3_i  in  3, Funct7_i  in  7  funct fields
- Rd_i, Rs1_i, Rs2_i  in  5 each  register indices
- Imm_i  in  32  immediate, byte offset for B/J, full value for U
- Last_i  in  1  marks final descriptor, sampled with handshake
- Mem_Write_o  out  1  write request
- Mem_Addr_o  out  ADDR_WIDTH  word address
- Mem_Data_o  out  32  encoded instruction
- Mem_Ack_i  in  1  memory accepted write this cycle
- Busy_o  out  1  state is ACCEPT or WRITE
- Done_o  out  1  session complete (sticky until Start_i)
- Count_o  out  ADDR_WIDTH+1  words written this session
- Error_o  out  1  sticky illegal-immediate flag (see Configuration)

## Operation
- Opcodes: R 0x33, I_LOGIC 0x13, I_LOAD 0x03, S 0x23, U 0x37, B 0x63, JAL 0x6F, JALR 0x67.
- Packing:
  - R: f7|rs2|rs1|f3|rd|op
  - I/I_LOAD/JALR: imm[11:0]|rs1|f3|rd|op, with JALR f3 forced to 0
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - Fields unused by a class are ignored.
- FSM states IDLE, ACCEPT, WRITE, DONE:
  - IDLE: Start_i → ACCEPT; address = BASE_ADDR, Count_o = 0, Error_o = 0.
  - ACCEPT: Desc_Ready_o = 1. On handshake, register the encoded word and Last_i, then → WRITE.
  - WRITE: Mem_Write_o = 1, with address and data held stable until Mem_Ack_i. On ack, address+1 and Count_o+1. Then:
    - → DONE if registered Last is set, or if Count_o reaches 2^ADDR_WIDTH (address wrap is never written);
    - → ACCEPT otherwise.
  - DONE: Done_o = 1. Start_i → ACCEPT with counters reinitialised as in IDLE.
- Start_i is ignored in ACCEPT and WRITE.
- Desc_Ready_o is never asserted in IDLE, WRITE or DONE.

## Timing
- Reset values: state IDLE, Desc_Ready_o 0, Mem_Write_o 0, Mem_Addr_o BASE_ADDR, Mem_Data_o 0, Busy_o 0, Done_o 0, Count_o 0, Error_o 0.
- Reset in any state, including mid-WRITE, takes effect at that edge. The pending write is dropped.
- Handshake at edge N → Mem_Write_o high from N+1. If Mem_Ack_i is high in cycle N+1, Desc_Ready_o is high in cycle N+2. Peak throughput is one word per two cycles.
- Mem_Ack_i sampled while not in WRITE is ignored.
- Done_o rises the cycle after the final ack.

## Configuration
- IMM_CHECK_EN defined: an illegal immediate is accepted (handshake completes) but not written. Error_o sets and stays set until Start_i; address and Count_o do not advance. If Last_i was set with it, the block goes to DONE. Illegal means:
  - I/S: not sign-representable in 12 bits;
  - B: bit 0 set or outside 13-bit signed;
  - JAL: bit 0 set or outside 21-bit signed;
  - U: imm[11:0] ≠ 0.
- IMM_CHECK_EN undefined: immediates are truncated silently; Error_o is tied 0.

## Structure
- Shared package rv_isa_pkg: opcode constants (shared with the control decoder), Desc_Type codes, FSM state encoding.
- Sub-module instr_field_packer: purely combinational descriptor→word packing plus the illegal-immediate check. The top level holds the FSM, counters and output registers.

## Test plan
- R add x3,x1,x2 (type 0, f3 0, f7 0) with Last_i → Mem_Data_o = 0x002081B3 at address 0, Count_o = 1, Done_o = 1.
- I_LOGIC addi x1,x0,5 then S sw x2,8(x1) (f3 2) → 0x00500093 at address 0, 0x0020A423 at address 1.
- B beq x1,x2,imm −8 → 0xFE208CE3; JALR x1,0(x5) with Funct3_i = 3 → 0x000280E7 (f3 forced 0).
- Mem_Ack_i held low 3 cycles → Mem_Write_o, address and data stable; Desc_Ready_o low; next descriptor accepted only after the ack.
- Reset (low) in WRITE → all outputs at reset values next cycle; a new Start_i restarts at BASE_ADDR.
- IMM_CHECK_EN: addi with imm 0x800 → no write, Error_o = 1, Count_o unchanged; following valid descriptor still written at the same address.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I opcode constants, descriptor type codes and loader FSM encoding shared by the
// instruction encoder/loader and the core's control decoder.
package rv_isa_pkg;

    localparam logic [6:0] OP_R       = 7'h33;
    localparam logic [6:0] OP_I_LOGIC = 7'h13;
    localparam logic [6:0] OP_I_LOAD  = 7'h03;
    localparam logic [6:0] OP_S       = 7'h23;
    localparam logic [6:0] OP_U       = 7'h37;
    localparam logic [6:0] OP_B       = 7'h63;
    localparam logic [6:0] OP_JAL     = 7'h6F;
    localparam logic [6:0] OP_JALR    = 7'h67;

    typedef enum logic [2:0] {
        DT_R        = 3'd0,
        DT_I_LOGIC  = 3'd1,
        DT_I_LOAD   = 3'd2,
        DT_S_STORE  = 3'd3,
        DT_U_LOAD   = 3'd4,
        DT_B_BRANCH = 3'd5,
        DT_JAL      = 3'd6,
        DT_JALR     = 3'd7
    } desc_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        desc_type_e  dtype;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } desc_t;

    // True when v[31:msb] are all copies of v[msb], i.e. v fits in (msb+1)-bit signed.
    function automatic logic is_sext(input logic [31:0] v, input int msb);
        logic ok;
        ok = 1'b1;
        for (int i = msb; i < 32; i++) begin
            if (v[i] != v[msb]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational descriptor -> RV32I word packer; zero latency, no flow control.
// IMM_CHECK_EN enables the illegal-immediate flag, otherwise immediates are truncated.
module instr_field_packer
    import rv_isa_pkg::*;
(
    input  desc_t       desc_i,
    output logic [31:0] word_o,
    output logic        imm_illegal_o
);

    logic [31:0] imm;
    assign imm = desc_i.imm;

    always_comb begin
        word_o = '0;
        case (desc_i.dtype)
            DT_R:        word_o = {desc_i.funct7, desc_i.rs2, desc_i.rs1, desc_i.funct3,
                                   desc_i.rd, OP_R};
            DT_I_LOGIC:  word_o = {imm[11:0], desc_i.rs1, desc_i.funct3, desc_i.rd, OP_I_LOGIC};
            DT_I_LOAD:   word_o = {imm[11:0], desc_i.rs1, desc_i.funct3, desc_i.rd, OP_I_LOAD};
            DT_S_STORE:  word_o = {imm[11:5], desc_i.rs2, desc_i.rs1, desc_i.funct3,
                                   imm[4:0], OP_S};
            DT_U_LOAD:   word_o = {imm[31:12], desc_i.rd, OP_U};
            DT_B_BRANCH: word_o = {imm[12], imm[10:5], desc_i.rs2, desc_i.rs1, desc_i.funct3,
                                   imm[4:1], imm[11], OP_B};
            DT_JAL:      word_o = {imm[20], imm[10:1], imm[11], imm[19:12], desc_i.rd, OP_JAL};
            // JALR has a single legal funct3, so the descriptor's value is discarded.
            DT_JALR:     word_o = {imm[11:0], desc_i.rs1, 3'b000, desc_i.rd, OP_JALR};
            default:     word_o = '0;
        endcase
    end

`ifdef IMM_CHECK_EN
    always_comb begin
        imm_illegal_o = 1'b0;
        case (desc_i.dtype)
            DT_I_LOGIC, DT_I_LOAD,
            DT_JALR, DT_S_STORE: imm_illegal_o = !is_sext(imm, 11);
            DT_B_BRANCH:         imm_illegal_o = imm[0] || !is_sext(imm, 12);
            DT_JAL:              imm_illegal_o = imm[0] || !is_sext(imm, 20);
            DT_U_LOAD:           imm_illegal_o = |imm[11:0];
            default:             imm_illegal_o = 1'b0;
        endcase
    end
`else
    logic unused_imm_lsb;
    assign unused_imm_lsb = imm[0];
    assign imm_illegal_o  = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes descriptors and writes them to consecutive instruction-memory words; one word per
// two cycles at best, Desc_Ready_o held low while a write awaits Mem_Ack_i. Option: IMM_CHECK_EN.
module instr_encoder_loader
    import rv_isa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic                  Desc_Valid_i,
    output logic                  Desc_Ready_o,
    input  logic [2:0]            Desc_Type_i,
    input  logic [2:0]            Funct3_i,
    input  logic [6:0]            Funct7_i,
    input  logic [4:0]            Rd_i,
    input  logic [4:0]            Rs1_i,
    input  logic [4:0]            Rs2_i,
    input  logic [31:0]           Imm_i,
    input  logic                  Last_i,
    output logic                  Mem_Write_o,
    output logic [ADDR_WIDTH-1:0] Mem_Addr_o,
    output logic [31:0]           Mem_Data_o,
    input  logic                  Mem_Ack_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic [ADDR_WIDTH:0]   Count_o,
    output logic                  Error_o
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    desc_t       desc;
    logic [31:0] enc_word;
    logic        imm_illegal;

    assign desc = '{dtype: desc_type_e'(Desc_Type_i), funct3: Funct3_i, funct7: Funct7_i,
                    rd: Rd_i, rs1: Rs1_i, rs2: Rs2_i, imm: Imm_i};

    instr_field_packer u_packer (
        .desc_i        (desc),
        .word_o        (enc_word),
        .imm_illegal_o (imm_illegal)
    );

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [31:0]           data_q, data_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic                  rdy_q, rdy_d;
    logic                  wr_q, wr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start_i) begin
                    state_d = ST_ACCEPT;
                    addr_d  = BASE;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (Desc_Valid_i) begin
                    // A rejected immediate still consumes the descriptor but never reaches memory.
                    if (imm_illegal) begin
                        err_d = 1'b1;
                        if (Last_i) state_d = ST_DONE;
                    end else begin
                        data_d  = enc_word;
                        last_d  = Last_i;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (Mem_Ack_i) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (last_q || cnt_d == CNT_FULL) ? ST_DONE : ST_ACCEPT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d  = (state_d == ST_ACCEPT);
        wr_d   = (state_d == ST_WRITE);
        busy_d = rdy_d || wr_d;
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Desc_Ready_o = rdy_q;
    assign Mem_Write_o  = wr_q;
    assign Mem_Addr_o   = addr_q;
    assign Mem_Data_o   = data_q;
    assign Busy_o       = busy_q;
    assign Done_o       = done_q;
    assign Count_o      = cnt_q;
    assign Error_o      = err_q;

endmodule
